// File: rtl/banked_register_file_pkg.sv
// Shared definitions for the banked register file: bank indices, address-width
// helper and the swap-handshake state encoding.
package banked_register_file_pkg;

    localparam logic BANK_MAIN   = 1'b0;
    localparam logic BANK_SHADOW = 1'b1;

    function automatic int addr_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    typedef enum logic {
        SWAP_ARMED,
        SWAP_HELD
    } swap_state_e;

endpackage

// File: rtl/banked_register_file_scoreboard.sv
// Per-register busy scoreboard: reserve sets, writeback clears, reserve wins a tie.
module banked_register_file_scoreboard
    import banked_register_file_pkg::*;
#(
    parameter int NUM_REGS  = 4,
    parameter int NUM_RD    = 2,
    parameter int AW        = 2,
    parameter int ZERO_REG0 = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 wr_en_i,
    input  logic [AW-1:0]        wr_addr_i,
    input  logic                 rsv_en_i,
    input  logic [AW-1:0]        rsv_addr_i,
    input  logic [NUM_RD*AW-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]    rd_busy_o,
    output logic                 any_busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if ((ZERO_REG0 == 0) || (r != 0)) begin
                if (wr_en_i && (wr_addr_i == AW'(r))) begin
                    busy_d[r] = 1'b0;
                end
                // Applied after the clear so a same-cycle reserve leaves the register busy.
                if (rsv_en_i && (rsv_addr_i == AW'(r))) begin
                    busy_d[r] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign any_busy_o = |busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_busy
        assign rd_busy_o[k] = busy_q[rd_addr_i[k*AW +: AW]];
    end

endmodule

// File: rtl/banked_register_file.sv
// Two-bank CPU register file with combinational read ports, optional write
// bypass, load scoreboard and an interrupt-driven bank-swap handshake.
module banked_register_file
    import banked_register_file_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NUM_REGS  = 4,
    parameter int NUM_RD    = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 0,
    localparam int AW       = addr_width(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wr_en_i,
    input  logic [AW-1:0]            wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rsv_en_i,
    input  logic [AW-1:0]            rsv_addr_i,
    input  logic                     swap_req_i,
    output logic                     swap_ack_o,
    output logic                     active_bank_o,
    output logic                     any_busy_o
);

    logic [DATA_W-1:0] mem_q [2*NUM_REGS];
    swap_state_e       state_q, state_d;
    logic              bank_q, bank_d;
    logic              ack_q;
    logic              swap_accept;
    logic              any_busy;
    logic              wr_ok;

    banked_register_file_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .NUM_RD    (NUM_RD),
        .AW        (AW),
        .ZERO_REG0 (ZERO_REG0)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .rsv_en_i   (rsv_en_i),
        .rsv_addr_i (rsv_addr_i),
        .rd_addr_i  (rd_addr_i),
        .rd_busy_o  (rd_busy_o),
        .any_busy_o (any_busy)
    );

    assign wr_ok = wr_en_i && !((ZERO_REG0 != 0) && (wr_addr_i == '0));

    // HELD keeps a still-asserted request from triggering a second swap.
    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        swap_accept = 1'b0;
        case (state_q)
            SWAP_ARMED: begin
                if (swap_req_i && !any_busy && !rsv_en_i) begin
                    swap_accept = 1'b1;
                    state_d     = SWAP_HELD;
                    bank_d      = (bank_q == BANK_MAIN) ? BANK_SHADOW : BANK_MAIN;
                end
            end
            SWAP_HELD: begin
                if (!swap_req_i) begin
                    state_d = SWAP_ARMED;
                end
            end
            default: state_d = SWAP_ARMED;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= SWAP_ARMED;
            bank_q  <= BANK_MAIN;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            ack_q   <= swap_accept;
        end
    end

    // The write uses the pre-edge bank, so a write in the swap cycle lands in the old bank.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < 2*NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[{bank_q, wr_addr_i}] <= wr_data_i;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;

        always_comb begin
            addr = rd_addr_i[k*AW +: AW];
            data = mem_q[{bank_q, addr}];
            if ((BYPASS != 0) && wr_en_i && (wr_addr_i == addr)) begin
                data = wr_data_i;
            end
            if ((ZERO_REG0 != 0) && (addr == '0)) begin
                data = '0;
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = data;
    end

    assign swap_ack_o    = ack_q;
    assign active_bank_o = bank_q;
    assign any_busy_o    = any_busy;

endmodule

// File: tb/tb_banked_register_file.sv
// Bench for banked_register_file: two instances (bypass on / R0 hardwired zero)
// driven in parallel and compared against a behavioural model.
module tb_banked_register_file;

    localparam int DW = 16;
    localparam int NR = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  rd_addr;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rsv_en;
    logic [1:0]  rsv_addr;
    logic        swap_req;

    logic [31:0] rdat  [2];
    logic [1:0]  rbusy [2];
    logic        ack   [2];
    logic        bank  [2];
    logic        anyb  [2];

    int checks = 0;
    int errors = 0;

    // Behavioural model, index 0 = bypass config, index 1 = zero-R0 config
    logic [15:0] m_mem   [2][2][NR];
    logic        m_busy  [2][NR];
    logic        m_bank  [2];
    logic        m_ack   [2];
    logic        m_armed [2];

    always #5 clk = ~clk;

    banked_register_file #(.DATA_W(16), .NUM_REGS(4), .NUM_RD(2), .BYPASS(1), .ZERO_REG0(0)) dut_a (
        .clk_i(clk), .reset_ni(reset_n), .rd_addr_i(rd_addr), .rd_data_o(rdat[0]), .rd_busy_o(rbusy[0]),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr),
        .swap_req_i(swap_req), .swap_ack_o(ack[0]), .active_bank_o(bank[0]), .any_busy_o(anyb[0]));

    banked_register_file #(.DATA_W(16), .NUM_REGS(4), .NUM_RD(2), .BYPASS(0), .ZERO_REG0(1)) dut_b (
        .clk_i(clk), .reset_ni(reset_n), .rd_addr_i(rd_addr), .rd_data_o(rdat[1]), .rd_busy_o(rbusy[1]),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr),
        .swap_req_i(swap_req), .swap_ack_o(ack[1]), .active_bank_o(bank[1]), .any_busy_o(anyb[1]));

    function automatic bit cfg_bypass(input int c); return c == 0; endfunction
    function automatic bit cfg_zero(input int c);   return c == 1; endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < NR; r++) m_mem[c][b][r] = '0;
            for (int r = 0; r < NR; r++) m_busy[c][r] = 1'b0;
            m_bank[c]  = 1'b0;
            m_ack[c]   = 1'b0;
            m_armed[c] = 1'b1;
        end
    endtask

    function automatic logic model_any(input int c);
        logic a;
        a = 1'b0;
        for (int r = 0; r < NR; r++) a = a | m_busy[c][r];
        return a;
    endfunction

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            bit acc;
            acc = swap_req && !model_any(c) && !rsv_en && m_armed[c];
            if (wr_en && !(cfg_zero(c) && wr_addr == 2'd0)) begin
                m_mem[c][m_bank[c]][wr_addr] = wr_data;
                m_busy[c][wr_addr] = 1'b0;
            end
            if (rsv_en && !(cfg_zero(c) && rsv_addr == 2'd0)) m_busy[c][rsv_addr] = 1'b1;
            m_ack[c] = acc;
            if (acc) m_bank[c] = ~m_bank[c];
            if (acc) m_armed[c] = 1'b0;
            else if (!swap_req) m_armed[c] = 1'b1;
        end
    endtask

    function automatic logic [15:0] exp_rd(input int c, input int k);
        logic [1:0]  a;
        logic [15:0] d;
        a = rd_addr[k*2 +: 2];
        d = m_mem[c][m_bank[c]][a];
        if (cfg_bypass(c) && wr_en && wr_addr == a) d = wr_data;
        if (cfg_zero(c) && a == 2'd0) d = '0;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en = 0; rsv_en = 0; swap_req = 0; rd_addr = '0;
        wr_addr = '0; rsv_addr = '0; wr_data = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        model_reset();
        #4;
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < NR; a++) begin
                rd_addr = {2'(a), 2'(a)};
                #1;
                checks++;
                if (rdat[c] !== 32'h0 || rbusy[c] !== 2'b00) begin
                    errors++;
                    $display("FAIL reset_read cfg%0d r%0d: got data %h busy %b, expected 0 0", c, a, rdat[c], rbusy[c]);
                end
            end
            checks++;
            if (ack[c] !== 1'b0 || bank[c] !== 1'b0 || anyb[c] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl cfg%0d: got ack %b bank %b any %b, expected 0 0 0", c, ack[c], bank[c], anyb[c]);
            end
        end
        tick();
        reset_n = 1'b1;
        rd_addr = '0;
        tick();
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_addr = 2; wr_data = 16'hBEEF; rd_addr = {2'd0, 2'd2};
        #4;
        checks++;
        if (rdat[0][15:0] !== 16'hBEEF) begin
            errors++; $display("FAIL bypass_on: got %h expected BEEF", rdat[0][15:0]);
        end
        checks++;
        if (rdat[1][15:0] !== 16'h0000) begin
            errors++; $display("FAIL bypass_off: got %h expected 0000", rdat[1][15:0]);
        end
        tick();
        wr_en = 0;
        #4;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (rdat[c] !== {16'h0000, 16'hBEEF}) begin
                errors++; $display("FAIL write_then_read cfg%0d: got %h expected 0000BEEF", c, rdat[c]);
            end
        end
        tick();
    endtask

    task automatic test_scoreboard();
        rsv_en = 1; rsv_addr = 1; rd_addr = {2'd0, 2'd1};
        #4;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (rbusy[c][0] !== 1'b0) begin
                errors++; $display("FAIL busy_not_bypassed cfg%0d: got %b expected 0", c, rbusy[c][0]);
            end
        end
        tick();
        rsv_en = 0;
        wr_en = 1; wr_addr = 1; wr_data = 16'h0042;
        #4;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (rbusy[c][0] !== 1'b1 || anyb[c] !== 1'b1) begin
                errors++; $display("FAIL busy_after_rsv cfg%0d: got busy %b any %b expected 1 1", c, rbusy[c][0], anyb[c]);
            end
        end
        tick();
        wr_en = 0;
        #4;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (rbusy[c][0] !== 1'b0 || anyb[c] !== 1'b0 || rdat[c][15:0] !== 16'h0042) begin
                errors++; $display("FAIL busy_clear cfg%0d: got busy %b any %b data %h expected 0 0 0042", c, rbusy[c][0], anyb[c], rdat[c][15:0]);
            end
        end
        rsv_en = 1; rsv_addr = 1; wr_en = 1; wr_addr = 1; wr_data = 16'h0077;
        tick();
        rsv_en = 0; wr_en = 0;
        #4;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (rbusy[c][0] !== 1'b1 || rdat[c][15:0] !== 16'h0077) begin
                errors++; $display("FAIL rsv_wins cfg%0d: got busy %b data %h expected 1 0077", c, rbusy[c][0], rdat[c][15:0]);
            end
        end
        wr_en = 1; wr_addr = 1; wr_data = 16'h0077;
        tick();
        wr_en = 0;
    endtask

    task automatic test_swap_blocked();
        rsv_en = 1; rsv_addr = 3;
        tick();
        rsv_en = 0; swap_req = 1;
        for (int i = 0; i < 3; i++) begin
            #4;
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (ack[c] !== 1'b0 || bank[c] !== 1'b0) begin
                    errors++; $display("FAIL swap_blocked cfg%0d cyc%0d: got ack %b bank %b expected 0 0", c, i, ack[c], bank[c]);
                end
            end
            tick();
        end
        wr_en = 1; wr_addr = 3; wr_data = 16'h0333;
        tick();
        wr_en = 0;
        #4;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ack[c] !== 1'b0 || bank[c] !== 1'b0) begin
                errors++; $display("FAIL swap_pre_accept cfg%0d: got ack %b bank %b expected 0 0", c, ack[c], bank[c]);
            end
        end
        tick();
        #4;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ack[c] !== 1'b1 || bank[c] !== 1'b1) begin
                errors++; $display("FAIL swap_ack cfg%0d: got ack %b bank %b expected 1 1", c, ack[c], bank[c]);
            end
        end
        tick();
        #4;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (ack[c] !== 1'b0 || bank[c] !== 1'b1) begin
                errors++; $display("FAIL swap_held_req cfg%0d: got ack %b bank %b expected 0 1", c, ack[c], bank[c]);
            end
        end
        swap_req = 0; rd_addr = {2'd0, 2'd2};
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (rdat[c][15:0] !== 16'h0000) begin
                errors++; $display("FAIL shadow_empty cfg%0d: got %h expected 0000", c, rdat[c][15:0]);
            end
        end
        tick();
    endtask

    task automatic test_bank_toggle();
        wr_en = 1; wr_addr = 2; wr_data = 16'h1234;
        tick();
        wr_en = 0; swap_req = 1;
        tick();
        swap_req = 0; rd_addr = {2'd0, 2'd2};
        #4;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (bank[c] !== 1'b0 || rdat[c][15:0] !== 16'hBEEF) begin
                errors++; $display("FAIL swap_back cfg%0d: got bank %b data %h expected 0 BEEF", c, bank[c], rdat[c][15:0]);
            end
        end
        tick();
        swap_req = 1; wr_en = 1; wr_addr = 0; wr_data = 16'h5A5A;
        tick();
        swap_req = 0; wr_en = 0;
        #4;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (bank[c] !== 1'b1 || rdat[c] !== {16'h0000, 16'h1234}) begin
                errors++; $display("FAIL swap_again cfg%0d: got bank %b data %h expected 1 00001234", c, bank[c], rdat[c]);
            end
        end
        tick();
        swap_req = 1;
        tick();
        swap_req = 0;
        #4;
        checks++;
        if (rdat[0][31:16] !== 16'h5A5A) begin
            errors++; $display("FAIL old_bank_write: got %h expected 5A5A", rdat[0][31:16]);
        end
        checks++;
        if (rdat[1][31:16] !== 16'h0000) begin
            errors++; $display("FAIL zero_r0_swapwrite: got %h expected 0000", rdat[1][31:16]);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        rd_addr = {2'd0, 2'd0};
        wr_en = 1; wr_addr = 0; wr_data = 16'hFFFF; rsv_en = 1; rsv_addr = 0;
        tick();
        wr_en = 0; rsv_en = 0;
        #4;
        checks++;
        if (rdat[1][15:0] !== 16'h0000 || rbusy[1][0] !== 1'b0 || anyb[1] !== 1'b0) begin
            errors++; $display("FAIL zero_r0: got data %h busy %b any %b expected 0000 0 0", rdat[1][15:0], rbusy[1][0], anyb[1]);
        end
        checks++;
        if (rdat[0][15:0] !== 16'hFFFF || rbusy[0][0] !== 1'b1) begin
            errors++; $display("FAIL normal_r0: got data %h busy %b expected FFFF 1", rdat[0][15:0], rbusy[0][0]);
        end
        wr_en = 1; wr_addr = 0; wr_data = 16'h0000;
        tick();
        wr_en = 0;
    endtask

    task automatic test_reset_mid_swap();
        swap_req = 1;
        tick();
        #2;
        reset_n = 1'b0;
        model_reset();
        rd_addr = {2'd1, 2'd2};
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (bank[c] !== 1'b0 || ack[c] !== 1'b0 || rdat[c] !== 32'h0 || anyb[c] !== 1'b0) begin
                errors++; $display("FAIL reset_mid_swap cfg%0d: got bank %b ack %b data %h any %b expected 0 0 0 0", c, bank[c], ack[c], rdat[c], anyb[c]);
            end
        end
        swap_req = 0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rd_addr  = 4'($urandom);
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = 2'($urandom);
            wr_data  = 16'($urandom);
            rsv_en   = ($urandom_range(0, 3) == 0);
            rsv_addr = 2'($urandom);
            swap_req = ($urandom_range(0, 2) != 0);
            #4;
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < 2; k++) begin
                    logic [15:0] ed;
                    logic        eb;
                    ed = exp_rd(c, k);
                    eb = m_busy[c][rd_addr[k*2 +: 2]];
                    checks++;
                    if (rdat[c][k*16 +: 16] !== ed || rbusy[c][k] !== eb) begin
                        errors++;
                        $display("FAIL rand_read cfg%0d port%0d n%0d: got %h/%b expected %h/%b", c, k, n, rdat[c][k*16 +: 16], rbusy[c][k], ed, eb);
                    end
                end
                checks++;
                if (ack[c] !== m_ack[c] || bank[c] !== m_bank[c] || anyb[c] !== model_any(c)) begin
                    errors++;
                    $display("FAIL rand_ctrl cfg%0d n%0d: got ack %b bank %b any %b expected %b %b %b", c, n, ack[c], bank[c], anyb[c], m_ack[c], m_bank[c], model_any(c));
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_scoreboard();
        test_swap_blocked();
        test_bank_toggle();
        test_zero_reg();
        test_reset_mid_swap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
